instruction_dispatcher: RTL and testbench
=========================================

# instruction_dispatcher

Sequences decoded TPU instructions into the three execution controllers (weight, matrix-multiply, activation flow). Accepts one instruction at a time over a valid/ready handshake, classifies it by opcode and issues it to the owning controller once that controller and its data dependencies are idle. SYNCHRONIZE instructions drain all units. Sits between the instruction FIFO and the controllers in the TPU control path.

## Interface
- No parameters; all widths come from tpu_pkg (instr_type, opcode constants).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  global clock-enable; all state holds while low
- instr  in  instr_type  incoming instruction
- instr_valid  in  1  instr is valid
- instr_ready  out  1  dispatcher can accept instr this cycle
- wt_busy, wt_resource_busy  in  1 each  weight controller status
- mmu_busy, mmu_resource_busy  in  1 each  matrix-multiply controller status
- act_busy, act_resource_busy  in  1 each  activation flow controller status
- wt_instr, mmu_instr, act_instr  out  instr_type each  instruction to unit
- wt_instr_enable, mmu_instr_enable, act_instr_enable  out  1 each  one-cycle issue strobe
- synchronize  out  1  one-cycle pulse when a SYNCHRONIZE completes
- illegal_opcode  out  1  sticky; set on unrecognised opcode
- issued_count  out  32  number of instructions issued to units (NOP/SYNC excluded)

## Operation
- Opcode classes (tpu_pkg constants): NOP 8'h00; LOAD_WEIGHT 8'h08; SYNCHRONIZE 8'h0F; MATRIX_MULTIPLY opcode[7:4]=4'b0010; ACTIVATE opcode[7]=1; anything else illegal.
- States: IDLE, ISSUE, SYNC_WAIT.
- IDLE: instr_ready=1. On instr_valid (enable high) latch instr into holding register, go to ISSUE; NOP and illegal opcodes go to ISSUE and retire there without issue.
- ISSUE: instr_ready=0. Issue condition per class:
  - LOAD_WEIGHT: wt_busy=0.
  - MATRIX_MULTIPLY: mmu_busy=0 and wt_busy=0 (weights resident).
  - ACTIVATE: act_busy=0 and mmu_resource_busy=0 (accumulator results final).
  - SYNCHRONIZE: go to SYNC_WAIT immediately.
  - NOP: retire; illegal: set illegal_opcode, retire.
  - When condition true: registered strobe of target unit = 1 next cycle, target *_instr = held instruction, issued_count += 1 (wraps at 2^32), return to IDLE. Otherwise stay in ISSUE.
- SYNC_WAIT: when wt_resource_busy, mmu_resource_busy, act_resource_busy all 0 -> synchronize pulse next cycle, return to IDLE.
- *_instr outputs hold last issued instruction between issues.
- Strict in-order: a stalled instruction blocks all later ones.

## Timing
- Reset values: instr_ready=0 during reset, 1 the first cycle after; all strobes 0, synchronize 0, illegal_opcode 0, issued_count 0, *_instr all-zero, state IDLE.
- Accept at edge N -> ISSUE during cycle N..N+1 -> strobe high cycle N+1..N+2 (issue latency 2 edges from accept, zero stall).
- Strobes and synchronize are exactly one enabled cycle wide; if enable drops while high they hold and clear after the next enabled edge.
- After an issue, IDLE for one cycle minimum, so back-to-back issues are ≥2 cycles apart; unit busy (rises one edge after strobe) is therefore visible before the next evaluation — no extra guard.
- Status inputs are sampled combinationally in ISSUE/SYNC_WAIT; issue decision registered.
- rst mid-operation: held instruction discarded, no strobe emitted, counters/flags cleared.
- SYNCHRONIZE with all units idle: synchronize pulses 2 edges after accept.

## Structure
- tpu_pkg: opcode constants (NOP, LOAD_WEIGHT, SYNCHRONIZE, MATRIX_MULTIPLY prefix, ACTIVATE bit), dispatcher state enum.
- One natural sub-module: dispatch_hazard_check (combinational; instr class + status inputs -> can_issue, target one-hot).

## Test plan
- LOAD_WEIGHT (8'h08), all idle: accept at edge 1 -> wt_instr_enable high cycle 2 only, issued_count=1.
- ACTIVATE (8'h81) with mmu_resource_busy=1 for 10 cycles: instr_ready low, no act strobe until 1 cycle after mmu_resource_busy falls.
- MATRIX_MULTIPLY (8'h20) then ACTIVATE back-to-back with mmu_busy modelled: strobes strictly ordered, ≥2 cycles apart, in-order.
- SYNCHRONIZE with act_resource_busy high 20 cycles: synchronize pulses once, 1 cycle after it falls; no unit strobe.
- Opcode 8'h40: illegal_opcode sets and stays; issued_count unchanged; next instruction still dispatches.
- rst asserted in ISSUE with stalled ACTIVATE: no act strobe ever emitted; outputs at reset values next cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU control-path definitions.
//  - instr_type   : decoded instruction word passed from the instruction FIFO
//  - OP_*         : opcode constants used to classify instructions
//  - disp_state_e : instruction dispatcher state encoding
//  - instr_class_e: dispatch class derived from the opcode
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  flags;
    logic [15:0] length;
    logic [31:0] addr;
  } instr_type;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_LOAD_WEIGHT  = 8'h08;
  localparam logic [7:0] OP_SYNCHRONIZE  = 8'h0F;
  // MATRIX_MULTIPLY is any opcode whose upper nibble matches this prefix.
  localparam logic [3:0] OP_MMU_PREFIX   = 4'b0010;
  // ACTIVATE is any opcode with this bit set.
  localparam int         OP_ACTIVATE_BIT = 7;

  // Bit positions of the per-unit issue vectors.
  localparam int UNIT_WT  = 0;
  localparam int UNIT_MMU = 1;
  localparam int UNIT_ACT = 2;
  localparam int NUM_UNITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SYNC_WAIT
  } disp_state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WEIGHT,
    CLS_MMU,
    CLS_ACT,
    CLS_SYNC,
    CLS_ILLEGAL
  } instr_class_e;

  // Exact-match opcodes are tested before the prefix/bit classes so the
  // classes stay disjoint.
  function automatic instr_class_e classify_opcode(input logic [7:0] op);
    if (op == OP_NOP)                    return CLS_NOP;
    else if (op == OP_LOAD_WEIGHT)       return CLS_WEIGHT;
    else if (op == OP_SYNCHRONIZE)       return CLS_SYNC;
    else if (op[7:4] == OP_MMU_PREFIX)   return CLS_MMU;
    else if (op[OP_ACTIVATE_BIT])        return CLS_ACT;
    else                                 return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/dispatch_hazard_check.sv
// dispatch_hazard_check: combinational issue-condition evaluation.
// Ports:
//  cls_i                  class of the held instruction
//  *_busy_i               controller busy flags
//  *_resource_busy_i      controller resource (data dependency) busy flags
//  can_issue_o            held instruction may retire/issue/complete now
//  target_o               one-hot target unit {act, mmu, wt}; zero for
//                         NOP, SYNCHRONIZE and illegal instructions
module dispatch_hazard_check
  import tpu_pkg::*;
(
  input  instr_class_e         cls_i,
  input  logic                 wt_busy_i,
  input  logic                 wt_resource_busy_i,
  input  logic                 mmu_busy_i,
  input  logic                 mmu_resource_busy_i,
  input  logic                 act_busy_i,
  input  logic                 act_resource_busy_i,
  output logic                 can_issue_o,
  output logic [NUM_UNITS-1:0] target_o
);

  always_comb begin
    can_issue_o = 1'b0;
    target_o    = '0;
    case (cls_i)
      CLS_WEIGHT: begin
        can_issue_o        = !wt_busy_i;
        target_o[UNIT_WT]  = 1'b1;
      end
      CLS_MMU: begin
        // Multiply needs its own unit free and the weights fully resident.
        can_issue_o        = !mmu_busy_i && !wt_busy_i;
        target_o[UNIT_MMU] = 1'b1;
      end
      CLS_ACT: begin
        // Activation reads accumulators, so the MMU results must be final.
        can_issue_o        = !act_busy_i && !mmu_resource_busy_i;
        target_o[UNIT_ACT] = 1'b1;
      end
      CLS_SYNC: begin
        can_issue_o = !wt_resource_busy_i && !mmu_resource_busy_i &&
                      !act_resource_busy_i;
      end
      CLS_NOP, CLS_ILLEGAL: begin
        // Retire unconditionally; nothing is issued.
        can_issue_o = 1'b1;
      end
      default: begin
        can_issue_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher: in-order issue of decoded TPU instructions to the
// weight, matrix-multiply and activation controllers.
// Ports:
//  clk, rst, enable          clock, sync active-high reset, global clock enable
//  instr/instr_valid/ready   instruction handshake from the instruction FIFO
//  {wt,mmu,act}_busy         controller busy status
//  {wt,mmu,act}_resource_busy controller data-dependency status
//  {wt,mmu,act}_instr        last instruction issued to each controller
//  {wt,mmu,act}_instr_enable one-cycle issue strobes
//  synchronize               one-cycle pulse when a SYNCHRONIZE completes
//  illegal_opcode            sticky unrecognised-opcode flag
//  issued_count              instructions issued to controllers (wrapping)
module instruction_dispatcher
  import tpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  instr_type   instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        wt_busy,
  input  logic        wt_resource_busy,
  input  logic        mmu_busy,
  input  logic        mmu_resource_busy,
  input  logic        act_busy,
  input  logic        act_resource_busy,
  output instr_type   wt_instr,
  output instr_type   mmu_instr,
  output instr_type   act_instr,
  output logic        wt_instr_enable,
  output logic        mmu_instr_enable,
  output logic        act_instr_enable,
  output logic        synchronize,
  output logic        illegal_opcode,
  output logic [31:0] issued_count
);

  disp_state_e            state_q, state_d;
  instr_type              held_q;
  instr_class_e           held_cls;
  logic                   can_issue;
  logic [NUM_UNITS-1:0]   target;

  logic                   accept;
  logic                   issue_fire;
  logic                   sync_fire;
  logic                   illegal_fire;

  logic                   strobe_q     [NUM_UNITS];
  instr_type              unit_instr_q [NUM_UNITS];
  logic                   sync_q;
  logic                   illegal_q;
  logic [31:0]            count_q;

  assign held_cls = classify_opcode(held_q.opcode);

  dispatch_hazard_check u_hazard (
    .cls_i               (held_cls),
    .wt_busy_i           (wt_busy),
    .wt_resource_busy_i  (wt_resource_busy),
    .mmu_busy_i          (mmu_busy),
    .mmu_resource_busy_i (mmu_resource_busy),
    .act_busy_i          (act_busy),
    .act_resource_busy_i (act_resource_busy),
    .can_issue_o         (can_issue),
    .target_o            (target)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A SYNCHRONIZE whose units are already drained completes here
        // directly, keeping its latency equal to a normal issue.
        if (held_cls == CLS_SYNC) begin
          state_d = can_issue ? ST_IDLE : ST_SYNC_WAIT;
        end else if (can_issue) begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC_WAIT: begin
        if (can_issue) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    instr_ready  = 1'b0;
    accept       = 1'b0;
    issue_fire   = 1'b0;
    sync_fire    = 1'b0;
    illegal_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ready is withheld while enable is low so the producer never sees a
        // handshake that the dispatcher does not register.
        instr_ready = enable && !rst;
        accept      = instr_valid;
      end
      ST_ISSUE: begin
        issue_fire   = can_issue && (target != '0);
        sync_fire    = can_issue && (held_cls == CLS_SYNC);
        illegal_fire = (held_cls == CLS_ILLEGAL);
      end
      ST_SYNC_WAIT: begin
        sync_fire = can_issue;
      end
      default: ;
    endcase
  end

  // Holding register, flags and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q    <= '0;
      sync_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (enable) begin
      if (accept) held_q <= instr;
      sync_q <= sync_fire;
      if (illegal_fire) illegal_q <= 1'b1;
      if (issue_fire) count_q <= count_q + 32'd1;
    end
  end

  // Per-unit issue strobe and instruction register
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    always_ff @(posedge clk) begin
      if (rst) begin
        strobe_q[gi]     <= 1'b0;
        unit_instr_q[gi] <= '0;
      end else if (enable) begin
        strobe_q[gi] <= issue_fire && target[gi];
        if (issue_fire && target[gi]) unit_instr_q[gi] <= held_q;
      end
    end
  end

  assign wt_instr         = unit_instr_q[UNIT_WT];
  assign mmu_instr        = unit_instr_q[UNIT_MMU];
  assign act_instr        = unit_instr_q[UNIT_ACT];
  assign wt_instr_enable  = strobe_q[UNIT_WT];
  assign mmu_instr_enable = strobe_q[UNIT_MMU];
  assign act_instr_enable = strobe_q[UNIT_ACT];
  assign synchronize      = sync_q;
  assign illegal_opcode   = illegal_q;
  assign issued_count     = count_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Testbench for instruction_dispatcher: vector table, directed multi-cycle
// sequences and a randomized run against a one-slot behavioural model.
module tb_instruction_dispatcher;
  import tpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, instr_valid, instr_ready;
  instr_type   instr;
  logic        wt_busy, wt_resource_busy, mmu_busy, mmu_resource_busy;
  logic        act_busy, act_resource_busy;
  instr_type   wt_instr, mmu_instr, act_instr;
  logic        wt_instr_enable, mmu_instr_enable, act_instr_enable;
  logic        synchronize, illegal_opcode;
  logic [31:0] issued_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_dispatcher dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .wt_busy           (wt_busy),
    .wt_resource_busy  (wt_resource_busy),
    .mmu_busy          (mmu_busy),
    .mmu_resource_busy (mmu_resource_busy),
    .act_busy          (act_busy),
    .act_resource_busy (act_resource_busy),
    .wt_instr          (wt_instr),
    .mmu_instr         (mmu_instr),
    .act_instr         (act_instr),
    .wt_instr_enable   (wt_instr_enable),
    .mmu_instr_enable  (mmu_instr_enable),
    .act_instr_enable  (act_instr_enable),
    .synchronize       (synchronize),
    .illegal_opcode    (illegal_opcode),
    .issued_count      (issued_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic instr_type mk(input logic [7:0] op);
    instr_type t;
    t.opcode = op;
    t.flags  = 8'($urandom);
    t.length = 16'($urandom);
    t.addr   = $urandom;
    return t;
  endfunction

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h08;
      2:       return 8'h0F;
      3:       return {4'h2, 4'($urandom)};
      4:       return {1'b1, 7'($urandom)};
      5:       return 8'h40;
      6:       return 8'($urandom);
      default: return 8'h08;
    endcase
  endfunction

  // Outcome of evaluating a held instruction against the dispatch rules:
  // -1 stall, 0 weight issue, 1 mmu issue, 2 act issue, 3 sync done,
  // 4 NOP retire, 5 illegal retire.
  function automatic int rule_event(input logic [7:0] op,
                                    input logic wb, input logic wr,
                                    input logic mb, input logic mr,
                                    input logic ab, input logic ar);
    if (op == 8'h00) return 4;
    if (op == 8'h08) return wb ? -1 : 0;
    if (op == 8'h0F) return (wr || mr || ar) ? -1 : 3;
    if (op[7:4] == 4'h2) return (mb || wb) ? -1 : 1;
    if (op[7]) return (ab || mr) ? -1 : 2;
    return 5;
  endfunction

  task automatic status_idle();
    wt_busy = 0; wt_resource_busy = 0; mmu_busy = 0;
    mmu_resource_busy = 0; act_busy = 0; act_resource_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1; enable = 1; instr_valid = 0; instr = '0;
    status_idle();
    @(posedge clk);
    @(negedge clk);
    chk("reset_ready_low", 64'(instr_ready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [7:0] op);
    int waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      return;
    end
    instr = mk(op);
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  exp_strobe; // {act, mmu, wt}
    logic        exp_sync;
    logic        exp_ill;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_type exp_ins;
    logic [2:0] m_strobe;
    logic       m_has, m_sync, m_ill;
    logic [31:0] m_cnt;
    instr_type  m_ins;
    instr_type  m_last[3];
    int ev, pulses, first;

    vecs[0] = '{8'h08, 3'b001, 1'b0, 1'b0, 32'd1};
    vecs[1] = '{8'h20, 3'b010, 1'b0, 1'b0, 32'd1};
    vecs[2] = '{8'h2F, 3'b010, 1'b0, 1'b0, 32'd1};
    vecs[3] = '{8'h81, 3'b100, 1'b0, 1'b0, 32'd1};
    vecs[4] = '{8'hFF, 3'b100, 1'b0, 1'b0, 32'd1};
    vecs[5] = '{8'h0F, 3'b000, 1'b1, 1'b0, 32'd0};
    vecs[6] = '{8'h00, 3'b000, 1'b0, 1'b0, 32'd0};
    vecs[7] = '{8'h40, 3'b000, 1'b0, 1'b1, 32'd0};
    vecs[8] = '{8'h07, 3'b000, 1'b0, 1'b1, 32'd0};
    vecs[9] = '{8'h30, 3'b000, 1'b0, 1'b1, 32'd0};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_strobes", 64'({act_instr_enable, mmu_instr_enable, wt_instr_enable}), 64'd0);
    chk("rst_sync", 64'(synchronize), 64'd0);
    chk("rst_illegal", 64'(illegal_opcode), 64'd0);
    chk("rst_count", 64'(issued_count), 64'd0);
    chk("rst_wt_instr", wt_instr, 64'd0);
    chk("rst_act_instr", act_instr, 64'd0);

    // Table: one instruction, all units idle, 2-edge latency
    for (int v = 0; v < 10; v++) begin
      do_reset();
      exp_ins = mk(vecs[v].op);
      instr = exp_ins;
      instr_valid = 1;
      @(posedge clk); #1;
      instr_valid = 0;
      @(negedge clk);
      chk($sformatf("v%0d_ready_issue", v), 64'(instr_ready), 64'd0);
      chk($sformatf("v%0d_strobe_early", v),
          64'({act_instr_enable, mmu_instr_enable, wt_instr_enable}), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_strobe", v),
          64'({act_instr_enable, mmu_instr_enable, wt_instr_enable}), 64'(vecs[v].exp_strobe));
      chk($sformatf("v%0d_sync", v), 64'(synchronize), 64'(vecs[v].exp_sync));
      chk($sformatf("v%0d_illegal", v), 64'(illegal_opcode), 64'(vecs[v].exp_ill));
      chk($sformatf("v%0d_count", v), 64'(issued_count), 64'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_ready_back", v), 64'(instr_ready), 64'd1);
      if (vecs[v].exp_strobe[0]) chk($sformatf("v%0d_wt_instr", v), wt_instr, exp_ins);
      if (vecs[v].exp_strobe[1]) chk($sformatf("v%0d_mmu_instr", v), mmu_instr, exp_ins);
      if (vecs[v].exp_strobe[2]) chk($sformatf("v%0d_act_instr", v), act_instr, exp_ins);
      @(negedge clk);
      chk($sformatf("v%0d_strobe_clear", v),
          64'({act_instr_enable, mmu_instr_enable, wt_instr_enable, synchronize}), 64'd0);
      chk($sformatf("v%0d_illegal_sticky", v), 64'(illegal_opcode), 64'(vecs[v].exp_ill));
    end

    // ACTIVATE stalled by mmu_resource_busy for 10 cycles
    do_reset();
    mmu_resource_busy = 1;
    send(8'h81);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("actstall_ready", 64'(instr_ready), 64'd0);
      chk("actstall_strobe", 64'(act_instr_enable), 64'd0);
      @(posedge clk); #1;
    end
    mmu_resource_busy = 0;
    @(negedge clk);
    chk("actstall_not_yet", 64'(act_instr_enable), 64'd0);
    @(negedge clk);
    chk("actstall_strobe_after", 64'(act_instr_enable), 64'd1);
    @(negedge clk);
    chk("actstall_one_wide", 64'(act_instr_enable), 64'd0);

    // MATRIX_MULTIPLY then ACTIVATE back-to-back with mmu busy modelled
    do_reset();
    send(8'h20);
    @(negedge clk);
    chk("mm_act_mmu_early", 64'(mmu_instr_enable), 64'd0);
    @(negedge clk);
    chk("mm_act_mmu_strobe", 64'(mmu_instr_enable), 64'd1);
    chk("mm_act_ready_gap", 64'(instr_ready), 64'd1);
    instr = mk(8'h81);
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    mmu_busy = 1;
    mmu_resource_busy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mm_act_order", 64'({act_instr_enable, mmu_instr_enable}), 64'd0);
      @(posedge clk); #1;
    end
    mmu_busy = 0;
    mmu_resource_busy = 0;
    @(negedge clk);
    chk("mm_act_wait", 64'(act_instr_enable), 64'd0);
    @(negedge clk);
    chk("mm_act_act_strobe", 64'(act_instr_enable), 64'd1);
    chk("mm_act_count", 64'(issued_count), 64'd2);
    chk("mm_act_mmu_op", 64'(mmu_instr.opcode), 64'h20);
    chk("mm_act_act_op", 64'(act_instr.opcode), 64'h81);

    // SYNCHRONIZE drained by act_resource_busy for 20 cycles
    do_reset();
    act_resource_busy = 1;
    send(8'h0F);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("sync_wait_pulse", 64'(synchronize), 64'd0);
      chk("sync_wait_ready", 64'(instr_ready), 64'd0);
      @(posedge clk); #1;
    end
    act_resource_busy = 0;
    pulses = 0;
    first = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (synchronize) begin
        pulses++;
        if (first < 0) first = i;
      end
      chk("sync_no_unit_strobe",
          64'({act_instr_enable, mmu_instr_enable, wt_instr_enable}), 64'd0);
      @(posedge clk); #1;
    end
    chk("sync_pulse_count", 64'(pulses), 64'd1);
    chk("sync_pulse_time", 64'(first), 64'd1);
    chk("sync_count", 64'(issued_count), 64'd0);

    // Illegal opcode then LOAD_WEIGHT still dispatches
    do_reset();
    send(8'h40);
    send(8'h08);
    @(negedge clk);
    @(negedge clk);
    chk("ill_then_wt_strobe", 64'(wt_instr_enable), 64'd1);
    chk("ill_then_wt_illegal", 64'(illegal_opcode), 64'd1);
    chk("ill_then_wt_count", 64'(issued_count), 64'd1);

    // Reset while a stalled ACTIVATE is held
    do_reset();
    send(8'h08);
    send(8'h40);
    mmu_resource_busy = 1;
    send(8'h81);
    @(negedge clk);
    chk("rstmid_pre_illegal", 64'(illegal_opcode), 64'd1);
    chk("rstmid_pre_count", 64'(issued_count), 64'd1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstmid_ready_low", 64'(instr_ready), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    mmu_resource_busy = 0;
    @(negedge clk);
    chk("rstmid_ready", 64'(instr_ready), 64'd1);
    chk("rstmid_illegal", 64'(illegal_opcode), 64'd0);
    chk("rstmid_count", 64'(issued_count), 64'd0);
    chk("rstmid_wt_instr", wt_instr, 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("rstmid_no_act", 64'(act_instr_enable), 64'd0);
      @(negedge clk);
    end

    // Randomized run against a one-slot model: a held instruction retires at
    // the first enabled edge whose dispatch rule is satisfied; a new one is
    // accepted only when nothing is held.
    do_reset();
    m_has = 0; m_strobe = 0; m_sync = 0; m_ill = 0; m_cnt = 0; m_ins = '0;
    for (int u = 0; u < 3; u++) m_last[u] = '0;
    for (int c = 0; c < 3000; c++) begin
      enable            = ($urandom_range(0, 9) != 0);
      wt_busy           = ($urandom_range(0, 3) == 0);
      wt_resource_busy  = ($urandom_range(0, 3) == 0);
      mmu_busy          = ($urandom_range(0, 3) == 0);
      mmu_resource_busy = ($urandom_range(0, 3) == 0);
      act_busy          = ($urandom_range(0, 3) == 0);
      act_resource_busy = ($urandom_range(0, 3) == 0);
      instr_valid       = 1'($urandom_range(0, 1));
      instr             = mk(rand_op());
      @(negedge clk);
      chk($sformatf("rnd_ready@%0d", c), 64'(instr_ready), 64'(!m_has && enable));
      chk($sformatf("rnd_strobe@%0d", c),
          64'({act_instr_enable, mmu_instr_enable, wt_instr_enable}), 64'(m_strobe));
      chk($sformatf("rnd_sync@%0d", c), 64'(synchronize), 64'(m_sync));
      chk($sformatf("rnd_illegal@%0d", c), 64'(illegal_opcode), 64'(m_ill));
      chk($sformatf("rnd_count@%0d", c), 64'(issued_count), 64'(m_cnt));
      chk($sformatf("rnd_wt_instr@%0d", c), wt_instr, m_last[0]);
      chk($sformatf("rnd_mmu_instr@%0d", c), mmu_instr, m_last[1]);
      chk($sformatf("rnd_act_instr@%0d", c), act_instr, m_last[2]);
      if (enable) begin
        m_strobe = 0;
        m_sync = 0;
        if (m_has) begin
          ev = rule_event(m_ins.opcode, wt_busy, wt_resource_busy, mmu_busy,
                          mmu_resource_busy, act_busy, act_resource_busy);
          if (ev >= 0) begin
            m_has = 0;
            if (ev <= 2) begin
              m_strobe[ev] = 1'b1;
              m_last[ev] = m_ins;
              m_cnt = m_cnt + 32'd1;
            end else if (ev == 3) begin
              m_sync = 1;
            end else if (ev == 5) begin
              m_ill = 1;
            end
          end
        end else if (instr_valid) begin
          m_has = 1;
          m_ins = instr;
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
